panel_scan_driver: RTL
======================

// Module: panel_scan_driver
// PURPOSE
//  HUB75 scan/BCM driver for the 64x64 panel, downstream of panel_memory. Issues addr_top/addr_bottom,
//  takes pix_top/pix_bottom one clock later, shifts one bit-plane per row into the panel, then latches
//  and lights it. 8bpp binary-code modulation: bit b is lit for BASE_TICKS<<b clocks.
// PARAMETERS
//  COLS        64  columns per row (power of 2)
//  HALF_ROWS   32  rows per half; the top and bottom halves scan together
//  BPP         8   bits per colour channel
//  BASE_TICKS  4   lit clocks for bit-plane 0 (>=1)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   async active-low reset
//  enable       in   1   run scan; sampled at row boundaries
//  addr_top     out  12  {row[4:0]+0, col[5:0]} as row*COLS+col (combinational from regs)
//  addr_bottom  out  12  (row+HALF_ROWS)*COLS+col
//  pix_top      in   24  {R,G,B} 8b each, valid 1 clk after addr
//  pix_bottom   in   24  same, lower half
//  hub_r1/g1/b1 out  1   top-half data bits; hub_r2/g2/b2 out 1 bottom-half data bits
//  hub_clk      out  1   panel shift clock
//  hub_lat      out  1   latch strobe
//  hub_oe_n     out  1   output enable, active low
//  hub_row      out  5   row select A..E
//  frame_start  out  1   1-clk pulse at the start of row 0 / plane 0
//  busy         out  1   high whenever FSM != IDLE
// BEHAVIOUR
//  Reset: all outputs 0 except hub_oe_n=1; state IDLE, row=0, plane=0, col=0.
//  FSM: IDLE -> PREFETCH(2 clk) -> SHIFT(2*COLS clk) -> LATCH(1) -> DISPLAY(BASE_TICKS<<plane) -> next.
//  IDLE: leaves when enable=1; frame_start pulses on the PREFETCH entry when row=0 and plane=0.
//  PREFETCH clk0 presents col 0 address; pix arrives at the end of clk0; data regs load at the end of clk1.
//  SHIFT: each column is 2 clks: L (hub_clk=0, data stable, addr=col+1) then H (hub_clk=1).
//   Data regs reload at the end of each H. Memory latency 1 means the fetched column leads the shifted one by 1.
//  Data bits: hub_r1=pix_top[16+plane], hub_g1=pix_top[8+plane], hub_b1=pix_top[plane]; *2 use pix_bottom.
//  Last column (col=COLS-1): the fetch address wraps to col 0 and is ignored. Data regs clear to 0 after the shift.
//  hub_oe_n=1 during PREFETCH/SHIFT/LATCH. hub_row updates in LATCH only, never while hub_oe_n=0.
//  LATCH: hub_lat=1 for exactly 1 clk; hub_clk=0.
//  DISPLAY: hub_oe_n=0 for exactly BASE_TICKS<<plane clks. Counter width is clog2(BASE_TICKS<<(BPP-1))+1.
//  After DISPLAY: plane++. On plane==BPP-1: plane=0, row++ (mod HALF_ROWS). Then PREFETCH, or IDLE if enable=0.
//  enable drop mid-row: the current row finishes all BPP planes, then IDLE with hub_oe_n=1; row/plane keep position.
//  Row wrap 31->0: frame_start pulses on the next PREFETCH entry.
//  Async reset mid-DISPLAY: hub_oe_n=1 immediately, no partial latch.
// CONFIGURATION
//  BRIGHTNESS_EN defined: adds input brightness[7:0].
//   DISPLAY length is unchanged; hub_oe_n=0 only while tick < ((BASE_TICKS<<plane)*brightness)>>8.
//   Product is computed at full width before the shift, so the result never truncates.
//   brightness=0: panel stays dark but timing is identical.
//  BRIGHTNESS_EN undefined: port absent; hub_oe_n=0 for the whole DISPLAY.
// STRUCTURE
//  panel_pkg: COLS, HALF_ROWS, BPP, ADDR_W=12, PIX_W=24, channel bit offsets (R=16, G=8, B=0), FSM state encoding.
//  Sub-module hub75_bcm_timer: loads BASE_TICKS<<plane, counts down, outputs oe_active and done.
//   Holds the BRIGHTNESS_EN compare.
//  Top level holds the FSM, column/row/plane counters, the address generator and the data registers.
// TESTING (bench wraps a panel_memory model)
//  1 Reset asserted -> hub_oe_n=1, hub_lat=0, hub_clk=0, hub_row=0, busy=0, all data bits 0.
//  2 MEM[0]=FF0000, MEM[2048]=0000FF, plane 0 -> col0 shift: hub_r1=1, hub_b2=1, others 0.
//    Exactly 64 hub_clk rising edges before hub_lat.
//  3 BASE_TICKS=2, plane 3 -> hub_oe_n low exactly 16 consecutive clks; hub_lat 1 clk, 1 clk before.
//  4 Run through row 31 / plane 7 -> hub_row returns to 0; frame_start pulses once; period = 32 rows.
//  5 enable 1->0 at row 5 plane 2 -> planes 3..7 of row 5 complete, then IDLE, busy=0, hub_oe_n=1.
//    Resuming starts at row 6.
//  6 BRIGHTNESS_EN, BASE_TICKS=2, brightness=128, plane 3 -> oe low 8 of 16 clks.
//    brightness=0 -> oe never low.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared geometry, widths and FSM encoding for the HUB75 64x64 scan driver.
package panel_pkg;
   localparam int COLS           = 64;
   localparam int HALF_ROWS      = 32;
   localparam int BPP            = 8;
   localparam int DEF_BASE_TICKS = 4;
   localparam int ADDR_W         = 12;
   localparam int PIX_W          = 24;
   localparam int COL_W          = $clog2(COLS);
   localparam int ROW_W          = $clog2(HALF_ROWS);
   localparam int PLANE_W        = $clog2(BPP);
   localparam int R_OFS          = 16;
   localparam int G_OFS          = 8;
   localparam int B_OFS          = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREFETCH,
      ST_SHIFT,
      ST_LATCH,
      ST_DISPLAY
   } state_e;
endpackage

// File: rtl/hub75_bcm_timer.sv
// Binary-code-modulation lit-time counter; with BRIGHTNESS_EN the lit window is
// scaled by brightness/256 while the overall display slot length stays fixed.
module hub75_bcm_timer
   import panel_pkg::*;
#(
   parameter int BASE_TICKS = DEF_BASE_TICKS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [PLANE_W-1:0] plane,
`ifdef BRIGHTNESS_EN
   input  logic [7:0]         brightness,
`endif
   output logic               oe_active,
   output logic               done
);
   localparam int CNT_W = $clog2(BASE_TICKS << (BPP - 1)) + 1;

   logic [CNT_W-1:0] len_d;
   logic [CNT_W-1:0] count_q;
   logic             run_q;

   assign len_d = CNT_W'(BASE_TICKS) << plane;
   assign done  = run_q && (count_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q   <= 1'b0;
         count_q <= '0;
      end else if (load) begin
         run_q   <= 1'b1;
         count_q <= len_d - 1'b1;
      end else if (run_q) begin
         if (count_q == '0)
            run_q <= 1'b0;
         else
            count_q <= count_q - 1'b1;
      end
   end

`ifdef BRIGHTNESS_EN
   localparam int PROD_W = CNT_W + 8;

   logic [PROD_W-1:0] prod_d;
   logic [CNT_W-1:0]  tick_q;
   logic [CNT_W-1:0]  lit_q;

   // Full-width product so the >>8 never loses high bits.
   assign prod_d = PROD_W'(len_d) * PROD_W'(brightness);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q <= '0;
         lit_q  <= '0;
      end else if (load) begin
         tick_q <= '0;
         lit_q  <= CNT_W'(prod_d >> 8);
      end else if (run_q) begin
         tick_q <= tick_q + 1'b1;
      end
   end

   assign oe_active = run_q && (tick_q < lit_q);
`else
   assign oe_active = run_q;
`endif
endmodule

// File: rtl/panel_scan_driver.sv
// HUB75 scan/BCM driver: prefetch, shift one bit-plane per row, latch, light.
// Optional BRIGHTNESS_EN adds a brightness[7:0] input that dims the lit window.
module panel_scan_driver
   import panel_pkg::*;
#(
   parameter int BASE_TICKS = DEF_BASE_TICKS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
`ifdef BRIGHTNESS_EN
   input  logic [7:0]        brightness,
`endif
   output logic [ADDR_W-1:0] addr_top,
   output logic [ADDR_W-1:0] addr_bottom,
   input  logic [PIX_W-1:0]  pix_top,
   input  logic [PIX_W-1:0]  pix_bottom,
   output logic              hub_r1,
   output logic              hub_g1,
   output logic              hub_b1,
   output logic              hub_r2,
   output logic              hub_g2,
   output logic              hub_b2,
   output logic              hub_clk,
   output logic              hub_lat,
   output logic              hub_oe_n,
   output logic [ROW_W-1:0]  hub_row,
   output logic              frame_start,
   output logic              busy
);
   state_e             state_q;
   logic               phase_q;
   logic [COL_W-1:0]   col_q;
   logic [ROW_W-1:0]   row_q;
   logic [PLANE_W-1:0] plane_q;
   logic [5:0]         data_q;
   logic               hub_clk_q, hub_lat_q, frame_start_q, busy_q;
   logic [ROW_W-1:0]   hub_row_q;

   logic [BPP-1:0]     r_top, g_top, b_top, r_bot, g_bot, b_bot;
   logic [5:0]         pix_bits_d;
   logic [COL_W-1:0]   acol_d;
   logic [ROW_W-1:0]   row_inc_d;
   logic               timer_oe, timer_done;

   for (genvar gi = 0; gi < BPP; gi++) begin : g_chan
      assign r_top[gi] = pix_top[R_OFS + gi];
      assign g_top[gi] = pix_top[G_OFS + gi];
      assign b_top[gi] = pix_top[B_OFS + gi];
      assign r_bot[gi] = pix_bottom[R_OFS + gi];
      assign g_bot[gi] = pix_bottom[G_OFS + gi];
      assign b_bot[gi] = pix_bottom[B_OFS + gi];
   end

   assign pix_bits_d = {r_top[plane_q], g_top[plane_q], b_top[plane_q],
                        r_bot[plane_q], g_bot[plane_q], b_bot[plane_q]};

   // Fetch runs one column ahead while shifting; the last column wraps to 0 and is discarded.
   assign acol_d      = (state_q == ST_SHIFT) ? col_q + 1'b1 : col_q;
   assign addr_top    = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(acol_d);
   assign addr_bottom = (ADDR_W'(row_q) + ADDR_W'(HALF_ROWS)) * ADDR_W'(COLS) + ADDR_W'(acol_d);
   assign row_inc_d   = (row_q == ROW_W'(HALF_ROWS - 1)) ? '0 : row_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         phase_q       <= 1'b0;
         col_q         <= '0;
         row_q         <= '0;
         plane_q       <= '0;
         data_q        <= '0;
         hub_clk_q     <= 1'b0;
         hub_lat_q     <= 1'b0;
         hub_row_q     <= '0;
         frame_start_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         frame_start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (enable) begin
                  state_q       <= ST_PREFETCH;
                  phase_q       <= 1'b0;
                  col_q         <= '0;
                  busy_q        <= 1'b1;
                  frame_start_q <= (row_q == '0) && (plane_q == '0);
               end
            end
            ST_PREFETCH: begin
               if (!phase_q) begin
                  phase_q <= 1'b1;
               end else begin
                  phase_q <= 1'b0;
                  data_q  <= pix_bits_d;
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (!phase_q) begin
                  phase_q   <= 1'b1;
                  hub_clk_q <= 1'b1;
               end else begin
                  phase_q   <= 1'b0;
                  hub_clk_q <= 1'b0;
                  if (col_q == COL_W'(COLS - 1)) begin
                     data_q    <= '0;
                     col_q     <= '0;
                     hub_lat_q <= 1'b1;
                     hub_row_q <= row_q;
                     state_q   <= ST_LATCH;
                  end else begin
                     data_q <= pix_bits_d;
                     col_q  <= col_q + 1'b1;
                  end
               end
            end
            ST_LATCH: begin
               hub_lat_q <= 1'b0;
               state_q   <= ST_DISPLAY;
            end
            ST_DISPLAY: begin
               if (timer_done) begin
                  phase_q <= 1'b0;
                  // enable only matters once the whole row has shown every plane
                  if (plane_q == PLANE_W'(BPP - 1)) begin
                     plane_q <= '0;
                     row_q   <= row_inc_d;
                     if (enable) begin
                        state_q       <= ST_PREFETCH;
                        frame_start_q <= (row_inc_d == '0);
                     end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     plane_q <= plane_q + 1'b1;
                     state_q <= ST_PREFETCH;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   hub75_bcm_timer #(
      .BASE_TICKS (BASE_TICKS)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (state_q == ST_LATCH),
      .plane      (plane_q),
`ifdef BRIGHTNESS_EN
      .brightness (brightness),
`endif
      .oe_active  (timer_oe),
      .done       (timer_done)
   );

   assign {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} = data_q;
   assign hub_clk     = hub_clk_q;
   assign hub_lat     = hub_lat_q;
   assign hub_oe_n    = ~timer_oe;
   assign hub_row     = hub_row_q;
   assign frame_start = frame_start_q;
   assign busy        = busy_q;
endmodule
